// File: rtl/mmio_io_controller.sv
// -----------------------------------------------------------------------------
// mmio_io_controller
//
// Memory-mapped I/O block for the single-cycle processor. Data-memory accesses
// whose top address nibble equals IO_TAG are steered here. All other accesses
// go to data memory, and their stores are forwarded as memWrEn.
//
// Register map (offset = addr[4:2] * 4; addr[1:0] and the middle bits are
// ignored):
//   0x00 HEX    R/W
//   0x04 LEDR   R/W
//   0x08 LEDG   R/W
//   0x10 SW     RO  (synchronised, optionally debounced switches)
//   0x14 KEYCAP R/W1C (sticky press events; a new press beats a clear)
//   0x18 KEYLVL RO  (synchronised button level, 1 = pressed)
//   0x0C, 0x1C unmapped: read 0, writes ignored
//
// Ports:
//   clk      system clock (rising edge)
//   reset_n  asynchronous active-low reset
//   wrMEM    store strobe
//   addr     byte address
//   wrData   store data
//   sw       raw switches (asynchronous)
//   key      raw push buttons, active-low (asynchronous)
//   hex      HEX latch
//   ledr     red LED latch
//   ledg     green LED latch
//   rdData   I/O read data, zero-extended, combinational from state
//   isIoRead address lies in the I/O window
//   memWrEn  store to data memory (never for I/O addresses)
//
// Build option: define MMIO_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES switch
// debouncer. Without it, the SW register follows the synchronised switches
// every cycle.
// -----------------------------------------------------------------------------
module mmio_io_controller #(
  parameter int         DATA_BIT_WIDTH  = 32,
  parameter logic [3:0] IO_TAG          = 4'hF,
  parameter int         HEX_WIDTH       = 16,
  parameter int         LEDR_WIDTH      = 10,
  parameter int         LEDG_WIDTH      = 8,
  parameter int         SW_WIDTH        = 10,
  parameter int         KEY_WIDTH       = 4,
  parameter int         DEBOUNCE_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wrMEM,
  input  logic [DATA_BIT_WIDTH-1:0] addr,
  input  logic [DATA_BIT_WIDTH-1:0] wrData,
  input  logic [SW_WIDTH-1:0]       sw,
  input  logic [KEY_WIDTH-1:0]      key,
  output logic [HEX_WIDTH-1:0]      hex,
  output logic [LEDR_WIDTH-1:0]     ledr,
  output logic [LEDG_WIDTH-1:0]     ledg,
  output logic [DATA_BIT_WIDTH-1:0] rdData,
  output logic                      isIoRead,
  output logic                      memWrEn
);

  localparam logic [2:0] SEL_HEX    = 3'd0;
  localparam logic [2:0] SEL_LEDR   = 3'd1;
  localparam logic [2:0] SEL_LEDG   = 3'd2;
  localparam logic [2:0] SEL_SW     = 3'd4;
  localparam logic [2:0] SEL_KEYCAP = 3'd5;
  localparam logic [2:0] SEL_KEYLVL = 3'd6;

  // Address decode
  logic       is_io;
  logic [2:0] sel;
  logic       io_wr;

  assign is_io    = (addr[DATA_BIT_WIDTH-1 -: 4] == IO_TAG);
  assign sel      = addr[4:2];
  assign io_wr    = wrMEM & is_io;
  assign isIoRead = is_io;
  assign memWrEn  = wrMEM & ~is_io;

  // Only slices of the buses are decoded; fold the rest into one sink.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr, wrData};

  // Output latches
  logic [HEX_WIDTH-1:0]  hex_q,  hex_d;
  logic [LEDR_WIDTH-1:0] ledr_q, ledr_d;
  logic [LEDG_WIDTH-1:0] ledg_q, ledg_d;

  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    if (io_wr) begin
      case (sel)
        SEL_HEX:  hex_d  = wrData[HEX_WIDTH-1:0];
        SEL_LEDR: ledr_d = wrData[LEDR_WIDTH-1:0];
        SEL_LEDG: ledg_d = wrData[LEDG_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_q  <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
    end else begin
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
    end
  end

  assign hex  = hex_q;
  assign ledr = ledr_q;
  assign ledg = ledg_q;

  // Key path: two-flop synchroniser, previous sample, sticky capture.
  // The flops reset to all-ones (unpressed) so that reset release with the
  // buttons up cannot look like a falling edge.
  logic [KEY_WIDTH-1:0] key_s1_q, key_s2_q, key_prev_q;
  logic [KEY_WIDTH-1:0] keycap_q, keycap_d;
  logic [KEY_WIDTH-1:0] key_press;
  logic [KEY_WIDTH-1:0] key_clr;

  assign key_press = key_prev_q & ~key_s2_q;
  assign key_clr   = (io_wr && sel == SEL_KEYCAP) ? wrData[KEY_WIDTH-1:0] : '0;
  // The OR comes last so a press in the same cycle as a clear is not lost.
  assign keycap_d  = (keycap_q & ~key_clr) | key_press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_prev_q <= '1;
      keycap_q   <= '0;
    end else begin
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
      keycap_q   <= keycap_d;
    end
  end

  // Switch path: two-flop synchroniser, then the SW register
  logic [SW_WIDTH-1:0] sw_s1_q, sw_s2_q;
  logic [SW_WIDTH-1:0] sw_q, sw_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [SW_WIDTH-1:0] sw_cand_q, sw_cand_d;
  logic [CNT_W-1:0]    db_cnt_q,  db_cnt_d;

  // Any change restarts the count. The counter stops at CNT_LAST, so SW loads
  // only on the edge the count arrives there, and never again while the
  // input stays stable.
  always_comb begin
    sw_cand_d = sw_cand_q;
    db_cnt_d  = db_cnt_q;
    sw_d      = sw_q;
    if (sw_s2_q != sw_cand_q) begin
      sw_cand_d = sw_s2_q;
      db_cnt_d  = '0;
    end else if (db_cnt_q != CNT_LAST) begin
      db_cnt_d = db_cnt_q + 1'b1;
      if (db_cnt_q == CNT_PRE) begin
        sw_d = sw_cand_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_cand_q <= '0;
      db_cnt_q  <= '0;
      sw_q      <= '0;
    end else begin
      sw_cand_q <= sw_cand_d;
      db_cnt_q  <= db_cnt_d;
      sw_q      <= sw_d;
    end
  end
`else
  localparam int unused_db_cycles = DEBOUNCE_CYCLES;

  assign sw_d = sw_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_q <= '0;
    end else begin
      sw_q <= sw_d;
    end
  end
`endif

  // Read mux: zero outside the window and for unmapped offsets
  always_comb begin
    rdData = '0;
    if (is_io) begin
      case (sel)
        SEL_HEX:    rdData[HEX_WIDTH-1:0]  = hex_q;
        SEL_LEDR:   rdData[LEDR_WIDTH-1:0] = ledr_q;
        SEL_LEDG:   rdData[LEDG_WIDTH-1:0] = ledg_q;
        SEL_SW:     rdData[SW_WIDTH-1:0]   = sw_q;
        SEL_KEYCAP: rdData[KEY_WIDTH-1:0]  = keycap_q;
        SEL_KEYLVL: rdData[KEY_WIDTH-1:0]  = ~key_s2_q;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_io_controller.sv
// -----------------------------------------------------------------------------
// tb_mmio_io_controller
//
// Directed bench for mmio_io_controller. A table of store/read vectors checks
// the address decode, latches and read mux. Hand-written sequences cover
// switch latency (with or without MMIO_DEBOUNCE_EN), key capture, the
// set-beats-clear rule, and reset mid-debounce.
// -----------------------------------------------------------------------------
module tb_mmio_io_controller;

  logic        clk;
  logic        reset_n;
  logic        wrMEM;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [15:0] hex;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [31:0] rdData;
  logic        isIoRead;
  logic        memWrEn;

  int n_vec = 0;
  int n_bad = 0;

  mmio_io_controller #(
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wrMEM    (wrMEM),
    .addr     (addr),
    .wrData   (wrData),
    .sw       (sw),
    .key      (key),
    .hex      (hex),
    .ledr     (ledr),
    .ledg     (ledg),
    .rdData   (rdData),
    .isIoRead (isIoRead),
    .memWrEn  (memWrEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;    // read data before the edge
    logic        io;
    logic        we;
    logic [15:0] hex;   // latches after the edge
    logic [9:0]  ledr;
    logic [7:0]  ledg;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rd, input logic io, input logic we,
                              input logic [15:0] h, input logic [9:0] r, input logic [7:0] g);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.rd = rd; v.io = io; v.we = we;
    v.hex = h; v.ledr = r; v.ledg = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic peek(input logic [31:0] a, input string nm, input logic [31:0] exp);
    wrMEM = 1'b0;
    addr  = a;
    #1;
    chk(nm, rdData, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    wrMEM   = 1'b0;
    addr    = '0;
    wrData  = '0;
    sw      = '0;
    key     = 4'hF;

    //   wr    addr          data          rd_pre      io    we    hex       ledr     ledg
    tbl[0]  = mk(1'b0, 32'hF000_0000, 32'h0,         32'h0,      1'b1, 1'b0, 16'h0,    10'h0,   8'h0);
    tbl[1]  = mk(1'b1, 32'hF000_0000, 32'h0000_ABCD, 32'h0,      1'b1, 1'b0, 16'hABCD, 10'h0,   8'h0);
    tbl[2]  = mk(1'b0, 32'hF000_0000, 32'h0,         32'hABCD,   1'b1, 1'b0, 16'hABCD, 10'h0,   8'h0);
    tbl[3]  = mk(1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 32'h0,      1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'h0);
    tbl[4]  = mk(1'b1, 32'hF000_0008, 32'hFFFF_FFFF, 32'h0,      1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[5]  = mk(1'b1, 32'h1000_0004, 32'h1234_5678, 32'h0,      1'b0, 1'b1, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[6]  = mk(1'b0, 32'hF000_0004, 32'h0,         32'h3FF,    1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[7]  = mk(1'b0, 32'hF000_0008, 32'h0,         32'hFF,     1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[8]  = mk(1'b0, 32'hF000_000C, 32'h0,         32'h0,      1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[9]  = mk(1'b1, 32'hF000_001C, 32'h0000_0055, 32'h0,      1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[10] = mk(1'b1, 32'hF000_000C, 32'hFFFF_FFFF, 32'h0,      1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[11] = mk(1'b0, 32'hF000_001C, 32'h0,         32'h0,      1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[12] = mk(1'b1, 32'hF000_0010, 32'hFFFF_FFFF, 32'h0,      1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[13] = mk(1'b0, 32'hF000_0003, 32'h0,         32'hABCD,   1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[14] = mk(1'b0, 32'hF0FF_FFE0, 32'h0,         32'hABCD,   1'b1, 1'b0, 16'hABCD, 10'h3FF, 8'hFF);
    tbl[15] = mk(1'b1, 32'hF000_0002, 32'h0000_1234, 32'hABCD,   1'b1, 1'b0, 16'h1234, 10'h3FF, 8'hFF);
    tbl[16] = mk(1'b1, 32'hE000_0000, 32'h0,         32'h0,      1'b0, 1'b1, 16'h1234, 10'h3FF, 8'hFF);
    tbl[17] = mk(1'b1, 32'hF000_0004, 32'h0000_0C01, 32'h3FF,    1'b1, 1'b0, 16'h1234, 10'h001, 8'hFF);
    tbl[18] = mk(1'b1, 32'hF000_0004, 32'h0000_0002, 32'h001,    1'b1, 1'b0, 16'h1234, 10'h002, 8'hFF);
    tbl[19] = mk(1'b0, 32'hF000_0018, 32'h0,         32'h0,      1'b1, 1'b0, 16'h1234, 10'h002, 8'hFF);
    tbl[20] = mk(1'b1, 32'hF000_0014, 32'h0000_000F, 32'h0,      1'b1, 1'b0, 16'h1234, 10'h002, 8'hFF);
    tbl[21] = mk(1'b1, 32'h7F00_0000, 32'hFFFF_FFFF, 32'h0,      1'b0, 1'b1, 16'h1234, 10'h002, 8'hFF);
    tbl[22] = mk(1'b0, 32'h1234_5678, 32'h0,         32'h0,      1'b0, 1'b0, 16'h1234, 10'h002, 8'hFF);

    // Reset state
    #3;
    chk("rst_hex",  32'(hex),  32'h0);
    chk("rst_ledr", 32'(ledr), 32'h0);
    chk("rst_ledg", 32'(ledg), 32'h0);
    peek(32'hF000_0014, "rst_keycap", 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      wrMEM  = tbl[i].wr;
      addr   = tbl[i].a;
      wrData = tbl[i].d;
      #1;
      chk($sformatf("v%0d_rd", i),   rdData,           tbl[i].rd);
      chk($sformatf("v%0d_io", i),   32'(isIoRead),    32'(tbl[i].io));
      chk($sformatf("v%0d_we", i),   32'(memWrEn),     32'(tbl[i].we));
      @(posedge clk);
      #1;
      wrMEM = 1'b0;
      chk($sformatf("v%0d_hex", i),  32'(hex),         32'(tbl[i].hex));
      chk($sformatf("v%0d_ledr", i), 32'(ledr),        32'(tbl[i].ledr));
      chk($sformatf("v%0d_ledg", i), 32'(ledg),        32'(tbl[i].ledg));
    end

    // Switch latency
    @(negedge clk);
    sw = 10'h155;
`ifdef MMIO_DEBOUNCE_EN
    repeat (9) @(posedge clk);
    #1;
    peek(32'hF000_0010, "sw_edge9", 32'h0);
    @(posedge clk);
    #1;
    peek(32'hF000_0010, "sw_edge10", 32'h155);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sw = (i % 2 == 0) ? 10'h0AA : 10'h155;
      repeat (4) @(posedge clk);
      #1;
      peek(32'hF000_0010, $sformatf("sw_toggle%0d", i), 32'h155);
    end
`else
    repeat (2) @(posedge clk);
    #1;
    peek(32'hF000_0010, "sw_edge2", 32'h0);
    @(posedge clk);
    #1;
    peek(32'hF000_0010, "sw_edge3", 32'h155);
    @(negedge clk);
    sw = 10'h2AA;
    repeat (3) @(posedge clk);
    #1;
    peek(32'hF000_0010, "sw_follow", 32'h2AA);
`endif

    // key[2] pressed for 5 cycles
    @(negedge clk);
    key = 4'b1011;
    @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_e1", 32'h0);
    @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_e2", 32'h0);
    peek(32'hF000_0018, "keylvl_e2", 32'h4);
    @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_e3", 32'h4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    key = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_held", 32'h4);
    peek(32'hF000_0018, "keylvl_rel", 32'h0);
    @(negedge clk);
    wrMEM = 1'b1; addr = 32'hF000_0014; wrData = 32'h4;
    @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_w1c", 32'h0);

    // key[1] press lands on the same edge as a clear of bit 1
    @(negedge clk);
    key = 4'b1101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wrMEM = 1'b1; addr = 32'hF000_0014; wrData = 32'h2;
    @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_set_wins", 32'h2);
    @(negedge clk);
    wrMEM = 1'b1; addr = 32'hF000_0014; wrData = 32'h2;
    @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_clr_held", 32'h0);
    @(negedge clk);
    key = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_release", 32'h0);

    // Capture a key[0] press so reset has something to clear
    @(negedge clk);
    key = 4'b1110;
    repeat (3) @(posedge clk);
    @(negedge clk);
    key = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    peek(32'hF000_0014, "keycap_k0", 32'h1);

    // Reset in the middle of a debounce
    @(negedge clk);
    sw = 10'h0F0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_hex",  32'(hex),  32'h0);
    chk("midrst_ledr", 32'(ledr), 32'h0);
    chk("midrst_ledg", 32'(ledg), 32'h0);
    peek(32'hF000_0010, "midrst_sw", 32'h0);
    peek(32'hF000_0014, "midrst_keycap", 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
`ifdef MMIO_DEBOUNCE_EN
    repeat (7) @(posedge clk);
    #1;
    peek(32'hF000_0010, "sw_rst_restart", 32'h0);
    repeat (5) @(posedge clk);
    #1;
    peek(32'hF000_0010, "sw_rst_settled", 32'h0F0);
`else
    repeat (3) @(posedge clk);
    #1;
    peek(32'hF000_0010, "sw_rst_settled", 32'h0F0);
`endif
    peek(32'hF000_0014, "keycap_after_rst", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_io_controller.md
# mmio_io_controller

Parametrised memory-mapped I/O controller for the single-cycle processor. It decodes data-memory accesses into the I/O window. It holds registered output latches for HEX, LEDR and LEDG, and synchronises and optionally debounces the switch inputs. It captures push-button press events in sticky registers and returns I/O read data to the writeback mux. Non-I/O writes are forwarded as the data-memory write enable.

## Interface

Parameters:
- DATA_BIT_WIDTH, 32, address/data bus width; must be ≥ 8.
- IO_TAG, 4'hF, value of addr[DATA_BIT_WIDTH-1 -: 4] that selects the I/O window.
- HEX_WIDTH, 16, raw HEX value width (4 bits per digit; segment encoding downstream).
- LEDR_WIDTH, 10, red LED count.
- LEDG_WIDTH, 8, green LED count.
- SW_WIDTH, 10, switch count.
- KEY_WIDTH, 4, push-button count (buttons are active-low).
- DEBOUNCE_CYCLES, 1024, stable cycles required before the switch register updates (≥ 2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wrMEM  in  1  store strobe for the current instruction.
- addr  in  DATA_BIT_WIDTH  byte address of the access.
- wrData  in  DATA_BIT_WIDTH  store data.
- sw  in  SW_WIDTH  raw asynchronous switches.
- key  in  KEY_WIDTH  raw asynchronous buttons; 0 means pressed.
- hex  out  HEX_WIDTH  HEX latch.
- ledr  out  LEDR_WIDTH  LEDR latch.
- ledg  out  LEDG_WIDTH  LEDG latch.
- rdData  out  DATA_BIT_WIDTH  I/O read data, zero-extended.
- isIoRead  out  1  high when addr is in the I/O window; selects rdData over data memory.
- memWrEn  out  1  wrMEM & ~isIo.

## Operation

- isIo = (top 4 address bits == IO_TAG). Register select is addr[4:2]; addr[1:0] and addr[27:5] are ignored.
- Map (offset: register, access):
  - 0x00: HEX, R/W.
  - 0x04: LEDR, R/W.
  - 0x08: LEDG, R/W.
  - 0x10: SW (debounced), RO.
  - 0x14: KEYCAP (sticky press bits), R / write-1-to-clear.
  - 0x18: KEYLVL (synced, inverted so 1 = pressed), RO.
  - 0x0C, 0x1C: unmapped; read 0, writes ignored.
- Writes to R/W latches take wrData low bits truncated to the latch width. Writes to RO registers are ignored.
- Key path: 2-flop synchroniser, then previous-sample flop. A press is a previous=1, current=0 transition and sets the KEYCAP bit.
- KEYCAP write: every bit with wrData=1 is cleared. If a set and a clear hit the same bit in the same cycle, the set wins.
- Switch path: 2-flop synchroniser, then the debouncer (see Configuration), then the SW register.
- rdData is combinational from registered state. It is 0 when isIo=0 or the offset is unmapped.
- memWrEn is never asserted for I/O addresses. I/O latches never change for non-I/O addresses.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert expected upstream):
  - hex, ledr, ledg, SW register, KEYCAP, debounce counter and candidate all go to 0.
  - Key synchroniser and previous-sample flops go to all-ones (unpressed), so reset release never produces a spurious press.
- Store: a latch updates on the rising edge where wrMEM=1. The new value is visible on hex/ledr/ledg and rdData the following cycle. Back-to-back stores take effect in order, one per cycle.
- Key: a press appears in KEYCAP 3 edges after key falls (2 sync + edge detect). KEYLVL lags by 2 edges.
- Reset asserted mid-debounce discards the candidate. The counter restarts from 0 after release.
- The counter saturates; it does not wrap. A held stable input causes no repeated update.

## Configuration

- MMIO_DEBOUNCE_EN defined:
  - The debouncer holds a candidate and a counter of width $clog2(DEBOUNCE_CYCLES).
  - When the synced value ≠ candidate: candidate ← synced, counter ← 0.
  - Otherwise the counter increments until it reaches DEBOUNCE_CYCLES-1. On that edge SW ← candidate.
  - SW latency is 2 + DEBOUNCE_CYCLES edges after the last input change.
- MMIO_DEBOUNCE_EN undefined: no counter or candidate. SW ← synced value every cycle (latency 3 edges). DEBOUNCE_CYCLES is unused.

## Test plan

- Reset, then store 0x0000_ABCD to 0xF000_0000 → hex=16'hABCD next cycle; read 0xF000_0000 returns 0x0000_ABCD; memWrEn=0 throughout.
- Store 0xFFFF_FFFF to 0xF000_0004 and 0xF000_0008 → ledr=10'h3FF, ledg=8'hFF. Store to 0x1000_0004 → memWrEn=1 that cycle; ledr unchanged.
- With MMIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: sw=10'h155 held → read 0xF000_0010 gives 0x155 after 10 edges. Sw toggling every 4 cycles → SW never changes.
- key[2] pulsed low for 5 cycles → KEYCAP=0x4 after 3 edges and stays set after release. Write 0x4 to 0xF000_0014 → KEYCAP=0.
- New key[1] press on the same edge as a write-1-to-clear of bit 1 → bit 1 remains 1.
- Read 0xF000_000C and 0xF000_001C → 0. Assert reset_n=0 mid-debounce → all outputs 0 immediately, no press recorded after release.
